// File: rtl/gaussian_window_ctrl_if.sv
// gaussian_window_ctrl_if: pixel stream in, 3x3 tap window and status out
interface gaussian_window_ctrl_if #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int DATA_W     = 12
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  logic              pix_valid;
  logic              pix_sof;
  logic [DATA_W-1:0] pix_data;
  logic [DATA_W-1:0] win_00, win_01, win_02;
  logic [DATA_W-1:0] win_10, win_11, win_12;
  logic [DATA_W-1:0] win_20, win_21, win_22;
  logic              out_valid;
  logic [XW-1:0]     out_x;
  logic [YW-1:0]     out_y;
  logic              frame_done;
  logic              busy;
  modport master (
    output pix_valid, pix_sof, pix_data,
    input  win_00, win_01, win_02, win_10, win_11, win_12, win_20, win_21, win_22,
    input  out_valid, out_x, out_y, frame_done, busy
  );
  modport slave (
    input  pix_valid, pix_sof, pix_data,
    output win_00, win_01, win_02, win_10, win_11, win_12, win_20, win_21, win_22,
    output out_valid, out_x, out_y, frame_done, busy
  );
endinterface

// File: rtl/gaussian_window_ctrl.sv
// gaussian_window_ctrl: line buffers and 3x3 tap window sequencing for the Gaussian filter
module gaussian_window_ctrl #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int DATA_W     = 12
) (
  input logic                  clk,
  input logic                  reset,
  gaussian_window_ctrl_if.slave bus
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  state_t            state_q, state_d;
  logic [XW-1:0]     x_q, x_d, cx, out_x_q, out_x_d;
  logic [YW-1:0]     y_q, y_d, cy, out_y_q, out_y_d;
  logic              out_valid_q, out_valid_d, frame_done_q, frame_done_d, busy_q, busy_d;
  logic              acc, last;
  logic [DATA_W-1:0] lb0 [IMG_WIDTH];
  logic [DATA_W-1:0] lb1 [IMG_WIDTH];
  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] win_d [3][3];
  // accept decode, sof resync of coordinates, next-state, window shift and output strobes
  always_comb begin
    acc          = bus.pix_valid && (state_q != IDLE || bus.pix_sof);
    cx           = bus.pix_sof ? '0 : x_q;
    cy           = bus.pix_sof ? '0 : y_q;
    lb0_rd       = lb0[cx];
    lb1_rd       = lb1[cx];
    last         = cx == X_LAST && cy == Y_LAST;
    x_d          = !acc ? x_q : (cx == X_LAST) ? '0 : cx + XW'(1);
    y_d          = !acc ? y_q : last ? '0 : (cx == X_LAST) ? cy + YW'(1) : cy;
    state_d      = !acc ? state_q : last ? IDLE : (cy >= Y_TWO) ? RUN : FILL;
    out_valid_d  = acc && cx >= X_TWO && cy >= Y_TWO;
    out_x_d      = out_valid_d ? cx - XW'(1) : out_x_q;
    out_y_d      = out_valid_d ? cy - YW'(1) : out_y_q;
    frame_done_d = out_valid_d && last;
    busy_d       = state_d != IDLE;
    win_d        = win_q;
    if (acc) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = bus.pix_data;
    end
  end
  // control state, counters, taps and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      out_valid_q  <= 1'b0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      win_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      out_valid_q  <= out_valid_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      win_q        <= win_d;
    end
  end
  // line buffers age one row per accept; the read above sees the pre-write contents
  always_ff @(posedge clk) begin
    if (acc) begin
      lb1[cx] <= lb0_rd;
      lb0[cx] <= bus.pix_data;
    end
  end
  assign bus.win_00     = win_q[0][0];
  assign bus.win_01     = win_q[0][1];
  assign bus.win_02     = win_q[0][2];
  assign bus.win_10     = win_q[1][0];
  assign bus.win_11     = win_q[1][1];
  assign bus.win_12     = win_q[1][2];
  assign bus.win_20     = win_q[2][0];
  assign bus.win_21     = win_q[2][1];
  assign bus.win_22     = win_q[2][2];
  assign bus.out_valid  = out_valid_q;
  assign bus.out_x      = out_x_q;
  assign bus.out_y      = out_y_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_gaussian_window_ctrl.sv
// tb_gaussian_window_ctrl: random-gap frame streams checked against a frame-array reference model
module tb_gaussian_window_ctrl;
  localparam int W = 8;
  localparam int H = 6;
  logic clk, reset;
  int n_chk, n_fail, n_pulse;
  int img [H][W];
  int ew [3][3];
  int mx, my;
  bit m_active, ramp_mode;
  logic [11:0] tp [3][3];
  gaussian_window_ctrl_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(12)) bus ();
  gaussian_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(12)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  assign tp[0][0] = bus.win_00;
  assign tp[0][1] = bus.win_01;
  assign tp[0][2] = bus.win_02;
  assign tp[1][0] = bus.win_10;
  assign tp[1][1] = bus.win_11;
  assign tp[1][2] = bus.win_12;
  assign tp[2][0] = bus.win_20;
  assign tp[2][1] = bus.win_21;
  assign tp[2][2] = bus.win_22;
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step(input logic v, input logic s, input logic [11:0] d);
    int ev, ex, ey, efd;
    ev = 0; ex = 0; ey = 0; efd = 0;
    @(negedge clk);
    bus.pix_valid = v;
    bus.pix_sof   = s;
    bus.pix_data  = d;
    if (v && (m_active || s)) begin
      if (s) begin mx = 0; my = 0; end
      img[my][mx] = int'(d);
      if (mx >= 2 && my >= 2) begin
        ev = 1; ex = mx - 1; ey = my - 1;
        efd = int'(mx == W - 1 && my == H - 1);
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) ew[r][c] = img[my - 2 + r][mx - 2 + c];
      end
      if (mx == W - 1 && my == H - 1) begin
        m_active = 0; mx = 0; my = 0;
      end else begin
        m_active = 1;
        if (mx == W - 1) begin mx = 0; my++; end else mx++;
      end
    end
    @(posedge clk);
    #1;
    if (bus.out_valid) n_pulse++;
    chk("out_valid", int'(bus.out_valid), ev);
    chk("frame_done", int'(bus.frame_done), efd);
    chk("busy", int'(bus.busy), int'(m_active));
    if (ev) begin
      chk("out_x", int'(bus.out_x), ex);
      chk("out_y", int'(bus.out_y), ey);
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) chk($sformatf("win_%0d%0d", r, c), int'(tp[r][c]), ew[r][c]);
      if (ramp_mode && ex == 1 && ey == 1) begin
        chk("ramp11_w00", int'(tp[0][0]), 'h000);
        chk("ramp11_w11", int'(tp[1][1]), 'h011);
        chk("ramp11_w22", int'(tp[2][2]), 'h022);
        chk("ramp11_w02", int'(tp[0][2]), 'h002);
      end
      if (ramp_mode && ex == 6 && ey == 4) chk("ramp64_w22", int'(tp[2][2]), 'h057);
    end
  endtask
  // mode 0 constant FFF, 1 ramp, 2 random; limit caps the number of pixels sent
  task automatic send_frame(input int mode, input int gap_pct, input int limit);
    int k;
    logic [3:0] yy, xx;
    k = 0;
    ramp_mode = (mode == 1);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        if (k < limit) begin
          while ($urandom_range(99) < gap_pct) step(1'b0, 1'b0, 12'($urandom));
          yy = 4'(y); xx = 4'(x);
          step(1'b1, x == 0 && y == 0,
               mode == 0 ? 12'hFFF : mode == 1 ? {4'h0, yy, xx} : 12'($urandom));
          k++;
        end
      end
  endtask
  initial begin
    n_chk = 0; n_fail = 0; n_pulse = 0;
    m_active = 0; mx = 0; my = 0; ramp_mode = 0;
    bus.pix_valid = 0; bus.pix_sof = 0; bus.pix_data = '0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_frame_done", int'(bus.frame_done), 0);
    chk("rst_out_x", int'(bus.out_x), 0);
    chk("rst_out_y", int'(bus.out_y), 0);
    chk("rst_win_11", int'(tp[1][1]), 0);
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 12'($urandom));
    chk("idle_pulses", n_pulse, 0);
    n_pulse = 0;
    send_frame(0, 0, W * H);
    chk("const_pulses", n_pulse, (W - 2) * (H - 2));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 12'h0);
    n_pulse = 0;
    send_frame(1, 0, W * H);
    chk("ramp_pulses", n_pulse, (W - 2) * (H - 2));
    n_pulse = 0;
    send_frame(1, 40, W * H);
    chk("gap_pulses", n_pulse, (W - 2) * (H - 2));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 12'($urandom));
    n_pulse = 0;
    send_frame(2, 20, 19);
    chk("partial_pulses", n_pulse, 1);
    n_pulse = 0;
    send_frame(2, 20, W * H);
    chk("resync_pulses", n_pulse, (W - 2) * (H - 2));
    send_frame(2, 0, 30);
    @(negedge clk);
    bus.pix_valid = 0;
    #2;
    reset = 1;
    #1;
    m_active = 0; mx = 0; my = 0;
    chk("arst_out_valid", int'(bus.out_valid), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_out_x", int'(bus.out_x), 0);
    chk("arst_win_22", int'(tp[2][2]), 0);
    @(negedge clk);
    reset = 0;
    n_pulse = 0;
    send_frame(0, 0, W * H);
    chk("post_rst_pulses", n_pulse, (W - 2) * (H - 2));
    step(1'b0, 1'b0, 12'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gaussian_window_ctrl.md
Name: gaussian_window_ctrl

Overview:
- Streaming controller that sequences the 3x3 Gaussian filter datapath.
- Accepts a raster-ordered 12-bit RGB444 pixel stream from the frame capture path.
- Maintains two line buffers and a 3x3 tap window, and presents the nine registered taps to the combinational Gaussian filter.
- Emits a one-cycle valid strobe with the centre coordinate, plus frame-level status.

Parameters:
- IMG_WIDTH, 320, active pixels per line (>=3)
- IMG_HEIGHT, 240, active lines per frame (>=3)
- DATA_W, 12, pixel width (RGB444)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pix_valid  in  1  pix_data is valid this cycle (accepted when high; no backpressure)
- pix_sof  in  1  start of frame; qualified by pix_valid; marks pixel (0,0)
- pix_data  in  DATA_W  input pixel
- win_00..win_22  out  DATA_W each  nine window taps, row r (0 = top), column c (0 = left/oldest), to the filter PixelData_rc inputs
- out_valid  out  1  taps hold a valid interior window this cycle
- out_x  out  $clog2(IMG_WIDTH)  centre column of current window
- out_y  out  $clog2(IMG_HEIGHT)  centre row of current window
- frame_done  out  1  one-cycle pulse coincident with the last out_valid of a frame
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, active-high):
  - state = IDLE; x/y counters = 0.
  - All taps, out_valid, out_x, out_y, frame_done and busy = 0.
  - Line-buffer RAM is not reset.
- Accept event = pix_valid && (state != IDLE || pix_sof). With pix_valid low, nothing changes and out_valid/frame_done = 0.
- States:
  - IDLE: drops pixels until an accepted pix_sof. That pixel is (0,0); go to FILL.
  - FILL: active while y < 2. Line buffers load; no out_valid. Move to RUN on acceptance of pixel (0,2).
  - RUN: outputs produced. After accepting pixel (IMG_WIDTH-1, IMG_HEIGHT-1), return to IDLE.
- Counters: on accept, x increments; at x = IMG_WIDTH-1, x wraps to 0 and y increments. pix_sof on any accepted pixel, in any state, forces that pixel to (0,0) and state to FILL (resync mid-frame). Stale buffer contents are overwritten before use.
- Line buffers: lb0 holds row y-1, lb1 holds row y-2, each IMG_WIDTH x DATA_W. On accept at column x:
  - read lb1[x] and lb0[x];
  - write lb1[x] <= lb0[x] (old value);
  - write lb0[x] <= pix_data.
  Read-before-write within the same cycle.
- Window shift on accept:
  - column 0 <= column 1; column 1 <= column 2;
  - column 2 <= {win_02 = lb1[x], win_12 = lb0[x], win_22 = pix_data}.
  - Taps do not change without an accept.
- Output timing:
  - After accepting (x,y) with x >= 2 and y >= 2, the taps are centred on (x-1, y-1).
  - Next cycle: out_valid = 1, out_x = x-1, out_y = y-1 (latency 1 cycle from the accepting edge).
  - Border centres (row/column 0 or the last row/column) are never emitted. Each frame yields exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) out_valid pulses.
  - At x < 2 the taps shift but out_valid = 0 (windows straddling the line wrap are suppressed).
- frame_done = out_valid for centre (IMG_WIDTH-2, IMG_HEIGHT-2).
- Simultaneous pix_sof and the last pixel of a frame: sof wins; the pixel becomes (0,0) and no frame_done is issued.

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=6):
- Constant frame 12'hFFF, pix_valid held high, sof on the first pixel -> 24 out_valid pulses; all taps = FFF; first pulse the cycle after the 19th accepted pixel, with out_x=1, out_y=1; frame_done with (6,4); busy drops to 0 after the last pixel.
- Ramp pixel = {4'h0, y[3:0], x[3:0]} -> at centre (1,1): win_00=0x000, win_11=0x011, win_22=0x022, win_02=0x002; at centre (6,4): win_22=0x057.
- Ramp with pix_valid randomly low about 40% of cycles -> out_valid/tap sequence identical to the gap-free run; no out_valid during gaps.
- pix_valid pixels while IDLE with no sof -> ignored, busy=0. pix_sof asserted at accepted pixel 20 mid-frame -> no out_valid until the new (2,2) is accepted; then out_x=1, out_y=1 with new-frame data.
- reset asserted mid-RUN -> all outputs 0 immediately (async). Next frame after release behaves as the constant-frame case: 24 pulses, correct taps.
